// File: rtl/vedic_mult8_pipe_if.sv
// rtl/vedic_mult8_pipe_if.sv - operand/result handshake bundle for the 8x8 Vedic multiplier
interface vedic_mult8_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      p;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, p, out_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, p, out_tag
  );
endinterface

// File: rtl/vedic_mult8_pipe.sv
// rtl/vedic_mult8_pipe.sv - 3-stage pipelined 8x8 unsigned Vedic multiplier with tag and result counter

// 2x2 Urdhva-Tiryagbhyam cell: vertical and crosswise bit products
module vedic_mult2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] z
);
  logic cross_a;
  logic cross_b;
  logic carry;

  assign cross_a = x[1] & y[0];
  assign cross_b = x[0] & y[1];
  assign carry   = cross_a & cross_b;
  assign z[0]    = x[0] & y[0];
  assign z[1]    = cross_a ^ cross_b;
  assign z[2]    = (x[1] & y[1]) ^ carry;
  assign z[3]    = (x[1] & y[1]) & carry;
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells and a small adder chain
module vedic_mult4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [4:0] mid;
  logic [5:0] t;
  logic [5:0] hi;

  vedic_mult2 u_q0 (.x(x[1:0]), .y(y[1:0]), .z(q0));
  vedic_mult2 u_q1 (.x(x[3:2]), .y(y[1:0]), .z(q1));
  vedic_mult2 u_q2 (.x(x[1:0]), .y(y[3:2]), .z(q2));
  vedic_mult2 u_q3 (.x(x[3:2]), .y(y[3:2]), .z(q3));

  assign mid = {1'b0, q1} + {1'b0, q2};
  assign t   = {1'b0, mid} + {4'b0, q0[3:2]};
  // top carry cannot be set: 15*15 >> 2 fits in 6 bits
  assign hi  = {q3, 2'b0} + t;
  assign z   = {hi, q0[1:0]};
endmodule

module vedic_mult8_pipe #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mult8_pipe_if.slave bus,
  output logic [CNT_W-1:0] res_count
);
  logic             stall;

  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [7:0]       ll_q, ll_d;
  logic [7:0]       hl_q, hl_d;
  logic [7:0]       lh_q, lh_d;
  logic [7:0]       hh_q, hh_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s3_valid_q, s3_valid_d;
  logic [15:0]      p_q, p_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       ll_w, hl_w, lh_w, hh_w;
  logic [8:0]       mid;
  logic [9:0]       t;
  logic [11:0]      p_hi;

  // the whole pipe freezes only when a finished result is refused
  assign stall = s3_valid_q & ~bus.out_ready;

  vedic_mult4 u_ll (.x(a_q[3:0]), .y(b_q[3:0]), .z(ll_w));
  vedic_mult4 u_hl (.x(a_q[7:4]), .y(b_q[3:0]), .z(hl_w));
  vedic_mult4 u_lh (.x(a_q[3:0]), .y(b_q[7:4]), .z(lh_w));
  vedic_mult4 u_hh (.x(a_q[7:4]), .y(b_q[7:4]), .z(hh_w));

  // recombine nibble products; the 12-bit top sum never overflows for 8x8
  always_comb begin
    mid  = {1'b0, hl_q} + {1'b0, lh_q};
    t    = {1'b0, mid} + {6'b0, ll_q[7:4]};
    p_hi = {hh_q, 4'b0} + {2'b0, t};
  end

  // advance all stages together unless stalled; data regs load only behind a valid bit
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    ll_d       = ll_q;
    hl_d       = hl_q;
    lh_d       = lh_q;
    hh_d       = hh_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    p_d        = p_q;
    s3_tag_d   = s3_tag_q;
    cnt_d      = cnt_q;
    if (!stall) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        a_d      = bus.a;
        b_d      = bus.b;
        s1_tag_d = bus.in_tag;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        ll_d     = ll_w;
        hl_d     = hl_w;
        lh_d     = lh_w;
        hh_d     = hh_w;
        s2_tag_d = s1_tag_q;
      end
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        p_d      = {p_hi, ll_q[3:0]};
        s3_tag_d = s2_tag_q;
      end
    end
    if (s3_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // pipeline and counter state; reset clears everything so no stale result survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      ll_q       <= '0;
      hl_q       <= '0;
      lh_q       <= '0;
      hh_q       <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      p_q        <= '0;
      s3_tag_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      ll_q       <= ll_d;
      hl_q       <= hl_d;
      lh_q       <= lh_d;
      hh_q       <= hh_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      p_q        <= p_d;
      s3_tag_q   <= s3_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = s3_valid_q;
  assign bus.p         = p_q;
  assign bus.out_tag   = s3_tag_q;
  assign res_count     = cnt_q;
endmodule

// File: tb/tb_vedic_mult8_pipe.sv
// tb/tb_vedic_mult8_pipe.sv - directed and sweep checks for vedic_mult8_pipe
module tb_vedic_mult8_pipe;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] res_count;
  int               n_checks;
  int               n_errors;

  vedic_mult8_pipe_if #(.TAG_W(TAG_W)) bus_if ();

  vedic_mult8_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = 8'h00;
    bus_if.b         = 8'h00;
    bus_if.in_tag    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [TAG_W-1:0] tv);
    bus_if.in_valid = 1'b1;
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.in_tag   = tv;
  endtask

  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  logic [31:0] exp_w;
  logic [7:0]  sa, sb;
  logic [15:0] sprod;
  logic [15:0] idx16;
  int          idx;
  int          delivered;
  int          cyc;
  bit          prev_xfer;
  bit          seen;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // reset / idle, with junk on the operand pins
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.a         = 8'h5A;
    bus_if.b         = 8'hC3;
    bus_if.in_tag    = 4'h9;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'h0);
    check("rst_p", {16'b0, bus_if.p}, 32'h0);
    check("rst_res_count", {16'b0, res_count}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("idle_out_valid", {31'b0, bus_if.out_valid}, 32'h0);
    check("idle_p", {16'b0, bus_if.p}, 32'h0);
    check("idle_res_count", {16'b0, res_count}, 32'h0);
    check("idle_in_ready", {31'b0, bus_if.in_ready}, 32'h1);

    // single op, latency exactly 3 cycles
    do_reset();
    bus_if.out_ready = 1'b1;
    @(negedge clk); drive(8'hFF, 8'hFF, 4'd3); #1;
    check("single_in_ready", {31'b0, bus_if.in_ready}, 32'h1);
    @(negedge clk); bus_if.in_valid = 1'b0; #1;
    check("single_lat1", {31'b0, bus_if.out_valid}, 32'h0);
    @(negedge clk); #1;
    check("single_lat2", {31'b0, bus_if.out_valid}, 32'h0);
    @(negedge clk); #1;
    check("single_valid", {31'b0, bus_if.out_valid}, 32'h1);
    check("single_p", {16'b0, bus_if.p}, 32'hFE01);
    check("single_tag", {28'b0, bus_if.out_tag}, 32'h3);
    @(negedge clk); #1;
    check("single_one_beat", {31'b0, bus_if.out_valid}, 32'h0);
    check("single_count", {16'b0, res_count}, 32'h1);

    // streaming back-to-back
    do_reset();
    bus_if.out_ready = 1'b1;
    @(negedge clk); drive(8'hA5, 8'h3C, 4'd1);
    @(negedge clk); drive(8'd12, 8'd13, 4'd2);
    @(negedge clk); drive(8'h00, 8'h80, 4'd3);
    @(negedge clk); bus_if.in_valid = 1'b0; #1;
    check("stream0", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd1, 16'h26AC});
    @(negedge clk); #1;
    check("stream1", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd2, 16'h009C});
    @(negedge clk); #1;
    check("stream2", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd3, 16'h0000});
    @(negedge clk); #1;
    check("stream_end", {31'b0, bus_if.out_valid}, 32'h0);
    check("stream_count", {16'b0, res_count}, 32'h3);

    // backpressure: three in flight, sink refuses for 5 cycles, a refused op is offered meanwhile
    do_reset();
    bus_if.out_ready = 1'b0;
    @(negedge clk); drive(8'h10, 8'h10, 4'd4);
    @(negedge clk); drive(8'h07, 8'h09, 4'd5);
    @(negedge clk); drive(8'hF0, 8'h0F, 4'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(8'h55, 8'h55, 4'hF); #1;
      check("bp_hold", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd4, 16'h0100});
      check("bp_in_ready", {31'b0, bus_if.in_ready}, 32'h0);
    end
    check("bp_count_stalled", {16'b0, res_count}, 32'h0);
    @(negedge clk); bus_if.out_ready = 1'b1; bus_if.in_valid = 1'b0; #1;
    check("bp_drain0", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd4, 16'h0100});
    @(negedge clk); #1;
    check("bp_drain1", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd5, 16'h003F});
    @(negedge clk); #1;
    check("bp_drain2", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd6, 16'h0E10});
    @(negedge clk); #1;
    check("bp_end", {31'b0, bus_if.out_valid}, 32'h0);
    check("bp_count", {16'b0, res_count}, 32'h3);

    // asynchronous reset with operations in flight
    do_reset();
    bus_if.out_ready = 1'b1;
    @(negedge clk); drive(8'd3, 8'd3, 4'd1);
    @(negedge clk); drive(8'd5, 8'd5, 4'd2);
    @(negedge clk); drive(8'd6, 8'd6, 4'd3);
    @(negedge clk); bus_if.in_valid = 1'b0; #1;
    check("mid_first", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd1, 16'h0009});
    @(negedge clk); bus_if.out_ready = 1'b0; #1;
    check("mid_second", {11'b0, bus_if.out_valid, bus_if.out_tag, bus_if.p}, {11'b0, 1'b1, 4'd2, 16'h0019});
    check("mid_count_pre", {16'b0, res_count}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus_if.out_valid}, 32'h0);
    check("mid_rst_count", {16'b0, res_count}, 32'h0);
    check("mid_rst_p", {16'b0, bus_if.p}, 32'h0);
    @(negedge clk); rst_n = 1'b1; bus_if.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      seen = seen | bus_if.out_valid;
    end
    check("mid_no_stale", {31'b0, seen}, 32'h0);

    // exhaustive sweep with random gaps on both sides
    do_reset();
    exp_q.delete();
    idx       = 0;
    delivered = 0;
    cyc       = 0;
    prev_xfer = 1'b0;
    while (delivered < 65536 && cyc < 90000) begin
      @(negedge clk);
      bus_if.out_ready = ($urandom_range(0, 63) != 0);
      if (idx < 65536) begin
        idx16           = idx[15:0];
        bus_if.in_valid = ($urandom_range(0, 63) != 0);
        bus_if.a        = idx16[15:8];
        bus_if.b        = idx16[7:0];
        bus_if.in_tag   = idx16[3:0] ^ idx16[11:8];
      end else begin
        bus_if.in_valid = 1'b0;
      end
      #1;
      if (prev_xfer && (delivered == 65535 || delivered[11:0] == 12'h000)) begin
        check("sweep_count", {16'b0, res_count}, {16'b0, delivered[15:0]});
      end
      prev_xfer = 1'b0;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          exp_w = {12'b0, exp_v};
        end else begin
          exp_w = 32'hFFFF_FFFF;
        end
        check("sweep_result", {12'b0, bus_if.out_tag, bus_if.p}, exp_w);
        delivered++;
        prev_xfer = 1'b1;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        sa    = bus_if.a;
        sb    = bus_if.b;
        sprod = 16'(sa) * 16'(sb);
        exp_q.push_back({bus_if.in_tag, sprod});
        idx++;
      end
      cyc++;
    end
    check("sweep_done", delivered, 32'd65536);
    @(negedge clk); bus_if.in_valid = 1'b0; #1;
    check("sweep_wrap", {16'b0, res_count}, 32'h0);
    check("sweep_leftover", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
